// File: rtl/seg_scan_6.sv
// Time-multiplexed seven-segment driver: snapshots BCD digits on load and scans them one slot at a time.
// Outputs are registered (1 cycle behind idx/guard); each slot is 1 dark cycle then SCAN_DIV-1 lit cycles.
module seg_scan_6 #(
  parameter int NDIG           = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   dp_mask,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);

  localparam logic [NDIG-1:0] AN_OFF  = {NDIG{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]      SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic            DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [4*NDIG-1:0] snap_q, snap_d;
  logic [NDIG-1:0]   lz_q, lz_d, lz_new;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              guard_q, guard_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              fd_q, fd_d;
  logic              wrap;
  logic              zero_run;
  logic [3:0]        cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // A digit is blanked only while every digit to its left is also zero.
  always_comb begin
    lz_new   = '0;
    zero_run = blank_lz;
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_run  = zero_run & (digits_in[4*k +: 4] == 4'd0);
      lz_new[k] = zero_run;
    end
  end

  always_comb begin
    snap_d  = load ? digits_in : snap_q;
    lz_d    = load ? lz_new : lz_q;
    wrap    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    guard_d   = wrap;
    fd_d      = wrap && (idx_q == IW'(NDIG - 1));
    cur_digit = snap_q[{idx_q, 2'b00} +: 4];

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (!guard_q) begin
      an_d  = (NDIG'(1) << idx_q) ^ AN_OFF;
      seg_d = lz_q[idx_q] ? SEG_OFF : (decode(cur_digit) ^ SEG_OFF);
      dp_d  = dp_mask[idx_q] ^ DP_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q  <= '0;
      lz_q    <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      guard_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      fd_q    <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      lz_q    <= lz_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_6.sv
// Directed bench for seg_scan_6 with NDIG=6, SCAN_DIV=4, active-low segments and anodes.
module tb_seg_scan_6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [23:0] digits_in = '0;
  logic [5:0]  dp_mask = '0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_err = 0;
  int n_chk = 0;
  bit scramble = 1'b0;

  logic [6:0] exp_seg [6];
  logic [5:0] exp_dp;

  seg_scan_6 #(
    .NDIG(6),
    .SCAN_DIV(4),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits_in(digits_in),
    .load(load),
    .blank_lz(blank_lz),
    .dp_mask(dp_mask),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (scramble) digits_in = 24'($urandom);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    if (frame_done !== 1'b1) check("frame_timeout", 32'(frame_done), 32'h1);
  endtask

  task automatic load_digits(input logic [23:0] d);
    digits_in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Starting at a frame_done cycle: slot k is dark at offset 4k+1 and lit from 4k+2.
  task automatic check_frame(input string tag);
    logic [5:0] ea;
    wait_frame();
    for (int k = 0; k < 6; k++) begin
      tick();
      check({tag, "_dark_an"}, 32'(an), 32'h3F);
      check({tag, "_dark_seg"}, 32'(seg), 32'h7F);
      check({tag, "_fd_low"}, 32'(frame_done), 32'h0);
      tick();
      ea = ~(6'b1 << k);
      check({tag, "_an"}, 32'(an), 32'(ea));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg[k]));
      check({tag, "_dp"}, 32'(dp), 32'(exp_dp[k]));
      tick();
      tick();
    end
    check({tag, "_fd_period"}, 32'(frame_done), 32'h1);
  endtask

  initial begin
    int n;
    exp_dp = 6'h3F;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_an", 32'(an), 32'h3F);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_fd", 32'(frame_done), 32'h0);
    end
    rst = 1'b1;
    tick();
    check("rel_dark_an", 32'(an), 32'h3F);
    tick();
    check("rel_an", 32'(an), 32'h3E);
    check("rel_seg", 32'(seg), 32'h40);
    check("rel_dp", 32'(dp), 32'h1);

    // Scan order and timing with digits 5..0
    load_digits(24'h543210);
    exp_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    check_frame("scan");

    // Leading-zero blanking
    blank_lz = 1'b1;
    load_digits(24'h001007);
    exp_seg = '{7'h78, 7'h40, 7'h40, 7'h79, 7'h7F, 7'h7F};
    check_frame("lz");
    load_digits(24'h000000);
    exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    check_frame("lz0");
    blank_lz = 1'b0;

    // Snapshot coherence: digits_in churns without load
    load_digits(24'h543210);
    scramble = 1'b1;
    exp_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    check_frame("hold");
    scramble = 1'b0;

    // Mid-slot load of digit0=9
    wait_frame();
    tick();
    tick();
    check("mid_pre_seg", 32'(seg), 32'h40);
    digits_in = 24'h543219;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("mid_same_seg", 32'(seg), 32'h40);
    tick();
    check("mid_new_seg", 32'(seg), 32'h10);
    check("mid_new_an", 32'(an), 32'h3E);
    n = 4;
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("mid_period", 32'(n), 32'd24);

    // Invalid BCD and decimal point
    dp_mask = 6'b000100;
    load_digits(24'h000C00);
    exp_seg = '{7'h40, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h40};
    exp_dp  = 6'b111011;
    check_frame("dp");
    dp_mask = 6'b000000;
    exp_dp  = 6'h3F;

    // Reset during the digit3 slot
    load_digits(24'h543210);
    wait_frame();
    for (int i = 0; i < 14; i++) tick();
    check("pre_rst_an", 32'(an), 32'h37);
    check("pre_rst_seg", 32'(seg), 32'h30);
    rst = 1'b0;
    tick();
    check("mid_rst_an", 32'(an), 32'h3F);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'h1);
    check("mid_rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b1;
    n = 0;
    tick();
    n++;
    check("post_rst_dark", 32'(an), 32'h3F);
    check("post_rst_fd1", 32'(frame_done), 32'h0);
    tick();
    n++;
    check("post_rst_an", 32'(an), 32'h3E);
    check("post_rst_seg", 32'(seg), 32'h40);
    check("post_rst_fd2", 32'(frame_done), 32'h0);
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("post_rst_period", 32'(n), 32'd24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
